sw_sb_ctrl: RTL
===============

Name: sw_sb_ctrl

Overview:
- System-bus responder for the 16 board switches; the input-side companion of the LED output controller.
- Synchronises and debounces sw_i, and exposes the stable value as a read-only bus register.
- Optionally raises a level interrupt on every debounced change; the interrupt is held until the core returns from the handler.
- Sits on the same peripheral bus slot decode as the other *_sb_ctrl blocks.

Parameters:
WIDTH, 16, number of switch inputs (≤ 32)
DEBOUNCE_CYCLES, 100_000, consecutive equal samples required before commit (≥ 2; benches use 4)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-low (asserted when 0)
req_i  input  1  bus request, single-cycle
write_enable_i  input  1  1 = write, 0 = read
addr_i  input  32  byte offset within block
write_data_i  input  32  write data
read_data_o  output  32  registered read data
sw_i  input  WIDTH  raw asynchronous switch levels
interrupt_request_o  output  1  level interrupt to core
interrupt_return_i  input  1  one-cycle pulse at handler return

Behaviour:
- Reset (rst_i==0 at a rising edge, or soft reset) clears every register on that edge: sync stages, candidate, counter, stable value, irq_en, pending, read_data_o. All outputs read 0 afterwards.
- Soft reset: a bus write to 0x24 with data == 32'd1 has the same effect as rst_i, taking effect on the same edge. Any other data at 0x24 is ignored.
- Synchroniser: two flops, sw_i → s1 → s2.
- Debounce, per vector (not per bit), using a candidate register and a counter cnt:
  - If s2 != candidate: candidate <= s2, cnt <= 0.
  - Else if candidate != stable: if cnt == DEBOUNCE_CYCLES-1, then stable <= candidate, cnt <= 0, and change_evt is pulsed for one cycle; otherwise cnt <= cnt+1.
  - Else: cnt <= 0.
- Latency: an sw_i value held constant and first sampled at edge 1 appears in stable at edge DEBOUNCE_CYCLES+3.
- Glitch rejection: a change that reverts before commit never alters stable.
- Register map (any other address is invalid):
  - 0x00: read-only {zero-pad, stable}. Writes are ignored.
  - 0x04: read/write irq_en in bit 0. Writes with data > 1 are ignored. Writing 0 also clears pending.
- Reads (req_i && !write_enable_i):
  - read_data_o updates on the next rising edge, one-cycle latency.
  - Valid address: the register value sampled at the request edge.
  - Invalid address: 32'hdead_beef.
  - Without a read request, read_data_o holds its last value; writes never change it.
- Interrupt:
  - pending is set on the edge where change_evt && irq_en.
  - pending is cleared on interrupt_return_i.
  - Set and clear in the same cycle: set wins.
  - interrupt_request_o = pending, driven directly from the flop.
  - While pending stays high, further changes do not queue extra interrupts.
- Simultaneous events:
  - A commit and a read of 0x00 on the same edge return the pre-commit stable value.
  - A soft-reset write beats every other update on that edge.
  - rst_i low beats everything.

Test Plan:
- Reset: drive rst_i=0 for 2 edges with sw_i=16'hFFFF → read_data_o=0, interrupt_request_o=0; a read of 0x00 issued right after reset returns 0.
- Debounce latency (DEBOUNCE_CYCLES=4): sw_i 0→16'hA5C3 held → stable updates at edge 7; a read of 0x00 requested at edge 8 gives read_data_o=32'h0000_A5C3 after edge 9.
- Glitch: sw_i=16'h0001 for 3 cycles, then back to 0 → stable stays 0, no interrupt.
- Interrupt handshake: write 0x04←1, toggle sw_i to 16'h8000 → interrupt_request_o rises on the commit edge. Further toggles while pending → still a single level. interrupt_return_i pulse → low next edge. A commit coinciding with the return pulse → stays high.
- Invalid accesses: read 0x10 → 32'hdead_beef. Write 0x04←2 → irq_en unchanged (read 0x04 returns 0). Write 0x00←5 → stable unchanged.
- Soft reset mid-debounce: irq_en=1 and pending=1, write 0x24←1 → next edge irq_en=0, interrupt_request_o=0, stable=0, and debounce restarts from the current sw_i.

Source files
------------

// File: rtl/sw_sb_ctrl.sv
// Bus responder for the board switches: two-flop synchroniser, whole-vector debounce,
// read-only switch register, and an optional level interrupt on every debounced change.
module sw_sb_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [WIDTH-1:0] sw_i,
    output logic             interrupt_request_o,
    input  logic             interrupt_return_i
);

    localparam int          CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [31:0] ADDR_STABLE = 32'h0000_0000;
    localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_0004;
    localparam logic [31:0] ADDR_SRST   = 32'h0000_0024;
    localparam logic [31:0] BAD_ADDR    = 32'hdead_beef;

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_en_q, irq_en_d;
    logic             pending_q, pending_d;
    logic [31:0]      rdata_q, rdata_d;

    logic rd_req, wr_req, soft_rst, change_evt, irq_en_wr;

    always_comb begin
        rd_req     = req_i && !write_enable_i;
        wr_req     = req_i && write_enable_i;
        soft_rst   = wr_req && (addr_i == ADDR_SRST) && (write_data_i == 32'd1);
        irq_en_wr  = wr_req && (addr_i == ADDR_IRQ_EN) && (write_data_i <= 32'd1);
        change_evt = 1'b0;

        s1_d      = sw_i;
        s2_d      = s1_q;
        cand_d    = cand_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        rdata_d   = rdata_q;

        // The whole vector must hold still; any bit moving restarts the count.
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d   = cand_q;
                cnt_d      = '0;
                change_evt = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (irq_en_wr) begin
            irq_en_d = write_data_i[0];
        end

        if (change_evt && irq_en_q) begin
            pending_d = 1'b1;
        end else if (interrupt_return_i) begin
            pending_d = 1'b0;
        end
        if (irq_en_wr && !write_data_i[0]) begin
            pending_d = 1'b0;
        end

        // Reads sample the current registers, so a same-edge commit is not yet visible.
        if (rd_req) begin
            case (addr_i)
                ADDR_STABLE: rdata_d = 32'(stable_q);
                ADDR_IRQ_EN: rdata_d = {31'd0, irq_en_q};
                default:     rdata_d = BAD_ADDR;
            endcase
        end

        if (soft_rst) begin
            s1_d      = '0;
            s2_d      = '0;
            cand_d    = '0;
            stable_d  = '0;
            cnt_d     = '0;
            irq_en_d  = 1'b0;
            pending_d = 1'b0;
            rdata_d   = '0;
        end
    end

    // NOTE: reset is synchronous and clears every register, including the read-data flop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
        end
    end

    assign read_data_o         = rdata_q;
    assign interrupt_request_o = pending_q;

endmodule
